imm_gen_stage: RTL and testbench

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

---
 rtl/imm_gen_pkg.sv | 31 +++
 rtl/imm_gen_stage_if.sv | 31 +++
 rtl/imm_decode.sv | 92 +++++++++
 rtl/imm_gen_stage.sv | 81 ++++++++
 tb/tb_imm_gen_stage.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types and RV opcode constants for the immediate-generation stage.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRX);
  endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Producer/consumer bundle of the immediate-generation stage.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  import imm_gen_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_fmt_t        out_fmt;
  logic            out_illegal;
  logic [CW-1:0]   count;

  modport slave (
    input  in_valid, in_inst, flush, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, count
  );

  modport master (
    output in_valid, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, count
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder: extracts and extends the immediate of
// one instruction word and classifies its format.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]             inst,
  output logic signed [XLEN-1:0]  imm,
  output imm_fmt_t                fmt,
  output logic                    illegal
);

  function automatic logic signed [XLEN-1:0] sext_w(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] zext_sh(input logic [5:0] v);
    return $signed(XLEN'(v));
  endfunction

  logic [6:0] opc;
  logic [2:0] funct3;
  logic signed [31:0] imm_i_w, imm_s_w, imm_b_w, imm_u_w, imm_j_w;
  logic [5:0] shamt_w;
  logic [5:0] shamt5_w;

  assign opc    = inst[6:0];
  assign funct3 = inst[14:12];

  // Each field is left-justified into a 32-bit signed word, then an
  // arithmetic right shift replicates inst[31] into the upper bits.
  assign imm_i_w = $signed(inst) >>> 20;
  assign imm_s_w = $signed({inst[31:25], inst[11:7], 20'b0}) >>> 20;
  assign imm_b_w = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0, 19'b0}) >>> 19;
  assign imm_u_w = $signed({inst[31:12], 12'b0});
  assign imm_j_w = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0, 11'b0}) >>> 11;

  // RV64 shifts take a 6-bit shamt; the word forms and RV32 take 5 bits.
  assign shamt5_w = {1'b0, inst[24:20]};
  assign shamt_w  = (XLEN == 64) ? inst[25:20] : shamt5_w;

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opc)
      OPC_OP_IMM: begin
        if (is_shift_f3(funct3)) begin
          fmt = FMT_SHAMT;
          imm = zext_sh(shamt_w);
        end else begin
          fmt = FMT_I;
          imm = sext_w(imm_i_w);
        end
      end
      OPC_LOAD, OPC_JALR: begin
        fmt = FMT_I;
        imm = sext_w(imm_i_w);
      end
      OPC_OP_IMM_32: begin
        if (XLEN != 64) begin
          illegal = 1'b1;
        end else if (is_shift_f3(funct3)) begin
          fmt = FMT_SHAMT;
          imm = zext_sh(shamt5_w);
        end else begin
          fmt = FMT_I;
          imm = sext_w(imm_i_w);
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = sext_w(imm_s_w);
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = sext_w(imm_b_w);
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = sext_w(imm_u_w);
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = sext_w(imm_j_w);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation stage: decodes each accepted instruction and queues
// the result in a small FIFO so the consumer can apply backpressure.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_gen_stage_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // ---- p0: decode of the offered word ----
  logic signed [XLEN-1:0] dec_imm_p0;
  imm_fmt_t               dec_fmt_p0;
  logic                   dec_ill_p0;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (bus.in_inst),
    .imm     (dec_imm_p0),
    .fmt     (dec_fmt_p0),
    .illegal (dec_ill_p0)
  );

  // ---- p1: result buffer ----
  logic signed [XLEN-1:0] mem_imm_p1 [DEPTH];
  imm_fmt_t               mem_fmt_p1 [DEPTH];
  logic                   mem_ill_p1 [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          vld_p1;
  logic          push, pop;

  assign vld_p1 = (cnt != '0);
  assign push   = bus.in_valid && bus.in_ready;
  assign pop    = vld_p1 && bus.out_ready;

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem_imm_p1[wr_ptr] <= dec_imm_p0;
      mem_fmt_p1[wr_ptr] <= dec_fmt_p0;
      mem_ill_p1[wr_ptr] <= dec_ill_p0;
    end
  end

  // ---- outputs: head entry, forced to zero while empty ----
  assign bus.in_ready    = (cnt < DEPTH_C);
  assign bus.out_valid   = vld_p1;
  assign bus.count       = cnt;
  assign bus.out_imm     = vld_p1 ? mem_imm_p1[rd_ptr] : '0;
  assign bus.out_fmt     = vld_p1 ? mem_fmt_p1[rd_ptr] : FMT_NONE;
  assign bus.out_illegal = vld_p1 ? mem_ill_p1[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: directed decode table, XLEN=64 companion,
// randomized FIFO traffic against a queue model, backpressure/flush/reset.
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en64 = 1'b0;
  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .DEPTH(4)) bus32 ();
  imm_gen_stage_if #(.XLEN(64), .DEPTH(2)) bus64 ();

  assign bus64.in_valid  = bus32.in_valid & en64;
  assign bus64.in_inst   = bus32.in_inst;
  assign bus64.flush     = bus32.flush & en64;
  assign bus64.out_ready = 1'b1;

  imm_gen_stage #(.XLEN(32), .DEPTH(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  imm_gen_stage #(.XLEN(64), .DEPTH(2)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    exp_t        e32;
    exp_t        e64;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: gather the immediate bits as a plain integer value,
  // then apply two's-complement interpretation of the field width.
  function automatic exp_t ref_dec(input logic [31:0] inst, input int xlen);
    exp_t   e;
    longint v;
    int     n;
    logic [2:0] f3;
    f3 = inst[14:12];
    v = 0; n = 0; e = '0;
    case (inst[6:0])
      7'h13: if (f3 == 3'd1 || f3 == 3'd5) begin
               e.fmt = 3'd6;
               v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
             end else begin e.fmt = 3'd1; v = longint'(inst[31:20]); n = 12; end
      7'h03, 7'h67: begin e.fmt = 3'd1; v = longint'(inst[31:20]); n = 12; end
      7'h1B: if (xlen != 64) e.ill = 1'b1;
             else if (f3 == 3'd1 || f3 == 3'd5) begin e.fmt = 3'd6; v = longint'(inst[24:20]); end
             else begin e.fmt = 3'd1; v = longint'(inst[31:20]); n = 12; end
      7'h23: begin e.fmt = 3'd2; v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]); n = 12; end
      7'h63: begin
               e.fmt = 3'd3; n = 13;
               v = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                 + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
             end
      7'h37, 7'h17: begin e.fmt = 3'd4; v = longint'(inst[31:12]) * 4096; n = 32; end
      7'h6F: begin
               e.fmt = 3'd5; n = 21;
               v = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
                 + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
             end
      default: e.ill = 1'b1;
    endcase
    if (n > 0 && v >= (longint'(1) <<< (n - 1))) v = v - (longint'(1) <<< n);
    e.imm = (xlen == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
    return e;
  endfunction

  task automatic apply_one(input logic [31:0] inst, input exp_t e32, input exp_t e64);
    bus32.in_valid = 1'b1;
    bus32.in_inst  = inst;
    step();
    bus32.in_valid = 1'b0;
    chk("lat1_valid32", 64'(bus32.out_valid), 64'd1);
    chk("imm32", 64'(bus32.out_imm), e32.imm);
    chk("fmt32", 64'(bus32.out_fmt), 64'(e32.fmt));
    chk("ill32", 64'(bus32.out_illegal), 64'(e32.ill));
    chk("count32_one", 64'(bus32.count), 64'd1);
    chk("lat1_valid64", 64'(bus64.out_valid), 64'd1);
    chk("imm64", bus64.out_imm, e64.imm);
    chk("fmt64", 64'(bus64.out_fmt), 64'(e64.fmt));
    chk("ill64", 64'(bus64.out_illegal), 64'(e64.ill));
    step();
    chk("idle_outs32", 64'({bus32.out_valid, bus32.out_illegal, bus32.out_fmt, bus32.out_imm}), 64'd0);
  endtask

  vec_t tbl[13];
  logic [6:0] ops[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus32.in_valid = 1'b0; bus32.in_inst = '0; bus32.flush = 1'b0; bus32.out_ready = 1'b0;

    tbl[0]  = '{32'hFFF00093, '{64'hFFFF_FFFF, 3'd1, 1'b0}, '{64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0}};
    tbl[1]  = '{32'hFE20AE23, '{64'hFFFF_FFFC, 3'd2, 1'b0}, '{64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0}};
    tbl[2]  = '{32'h123452B7, '{64'h1234_5000, 3'd4, 1'b0}, '{64'h1234_5000, 3'd4, 1'b0}};
    tbl[3]  = '{32'h0010006F, '{64'h0000_0800, 3'd5, 1'b0}, '{64'h0000_0800, 3'd5, 1'b0}};
    tbl[4]  = '{32'hFE000EE3, '{64'hFFFF_FFFC, 3'd3, 1'b0}, '{64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0}};
    tbl[5]  = '{32'h4030D093, '{64'h3, 3'd6, 1'b0}, '{64'h3, 3'd6, 1'b0}};
    tbl[6]  = '{32'h43F0D093, '{64'h1F, 3'd6, 1'b0}, '{64'h3F, 3'd6, 1'b0}};
    tbl[7]  = '{32'h00000000, '{64'h0, 3'd0, 1'b1}, '{64'h0, 3'd0, 1'b1}};
    tbl[8]  = '{32'h0010009B, '{64'h0, 3'd0, 1'b1}, '{64'h1, 3'd1, 1'b0}};
    tbl[9]  = '{32'h0230909B, '{64'h0, 3'd0, 1'b1}, '{64'h3, 3'd6, 1'b0}};
    tbl[10] = '{32'h800000B7, '{64'h8000_0000, 3'd4, 1'b0}, '{64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0}};
    tbl[11] = '{32'hFFC4A503, '{64'hFFFF_FFFC, 3'd1, 1'b0}, '{64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0}};
    tbl[12] = '{32'h00008067, '{64'h0, 3'd1, 1'b0}, '{64'h0, 3'd1, 1'b0}};
    ops = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h00, 7'h33, 7'h7F};

    // Reset state, observed while rst_n is held low.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 64'(bus32.count), 64'd0);
    chk("rst_valid", 64'(bus32.out_valid), 64'd0);
    chk("rst_ready", 64'(bus32.in_ready), 64'd1);
    chk("rst_outs", 64'({bus32.out_illegal, bus32.out_fmt, bus32.out_imm}), 64'd0);
    chk("rst_valid64", 64'(bus64.out_valid), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Directed decode table, then random words through both widths.
    en64 = 1'b1;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) apply_one(tbl[i].inst, tbl[i].e32, tbl[i].e64);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 11)];
      apply_one(w, ref_dec(w, 32), ref_dec(w, 64));
    end
    en64 = 1'b0;

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      logic do_push, do_pop;
      logic [31:0] w;
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 11)];
      bus32.in_valid  = ($urandom_range(0, 3) != 0);
      bus32.in_inst   = w;
      bus32.out_ready = ($urandom_range(0, 2) != 0);
      bus32.flush     = ($urandom_range(0, 31) == 0);
      chk("rnd_count", 64'(bus32.count), 64'(q.size()));
      chk("rnd_valid", 64'(bus32.out_valid), 64'(q.size() != 0));
      chk("rnd_ready", 64'(bus32.in_ready), 64'(q.size() < 4));
      if (q.size() != 0)
        chk("rnd_head", 64'({bus32.out_illegal, bus32.out_fmt, bus32.out_imm}),
            64'({q[0].ill, q[0].fmt, q[0].imm[31:0]}));
      else
        chk("rnd_idle", 64'({bus32.out_illegal, bus32.out_fmt, bus32.out_imm}), 64'd0);
      do_push = bus32.in_valid && (q.size() < 4);
      do_pop  = bus32.out_ready && (q.size() != 0);
      step();
      if (bus32.flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(ref_dec(w, 32));
      end
    end
    bus32.in_valid = 1'b0;
    bus32.flush = 1'b1;
    step();
    bus32.flush = 1'b0;
    q.delete();

    // Backpressure: five words offered into a four-entry buffer.
    bus32.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus32.in_valid = 1'b1;
      bus32.in_inst  = {20'(k + 1), 5'd0, 7'h37};
      chk("bp_in_ready", 64'(bus32.in_ready), 64'(k < 4));
      if (k < 4) step();
    end
    chk("bp_count_full", 64'(bus32.count), 64'd4);
    bus32.out_ready = 1'b1;
    begin
      int got;
      got = 0;
      for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
        logic took;
        took = bus32.in_valid && bus32.in_ready;
        if (bus32.out_valid) begin
          chk("bp_order", 64'(bus32.out_imm), 64'((got + 1) << 12));
          got++;
        end
        step();
        if (took) bus32.in_valid = 1'b0;
      end
      chk("bp_drained", 64'(got), 64'd5);
    end
    chk("bp_empty", 64'(bus32.count), 64'd0);

    // Flush with three entries and a same-cycle push.
    bus32.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus32.in_valid = 1'b1;
      bus32.in_inst  = 32'hFE20AE23;
      step();
    end
    chk("fl_count3", 64'(bus32.count), 64'd3);
    bus32.flush = 1'b1;
    bus32.in_inst = 32'h123452B7;
    step();
    bus32.flush = 1'b0;
    bus32.in_valid = 1'b0;
    chk("fl_count", 64'(bus32.count), 64'd0);
    chk("fl_valid", 64'(bus32.out_valid), 64'd0);
    chk("fl_outs", 64'({bus32.out_illegal, bus32.out_fmt, bus32.out_imm}), 64'd0);
    bus32.in_valid = 1'b1;
    bus32.in_inst  = 32'hFFF00093;
    step();
    bus32.in_valid = 1'b0;
    chk("fl_after_valid", 64'(bus32.out_valid), 64'd1);
    chk("fl_after_imm", 64'(bus32.out_imm), 64'hFFFF_FFFF);

    // Asynchronous reset in the middle of a cycle.
    bus32.in_valid = 1'b1;
    bus32.in_inst  = 32'h0010006F;
    step();
    bus32.in_valid = 1'b0;
    chk("ar_count2", 64'(bus32.count), 64'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_count", 64'(bus32.count), 64'd0);
    chk("ar_valid", 64'(bus32.out_valid), 64'd0);
    chk("ar_ready", 64'(bus32.in_ready), 64'd1);
    chk("ar_outs", 64'({bus32.out_illegal, bus32.out_fmt, bus32.out_imm}), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("ar_hold_count", 64'(bus32.count), 64'd0);
    chk("ar_hold_valid", 64'(bus32.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
